// File: rtl/maxil_read_top_if.sv
// maxil_read_top_if
//   AXI4-Lite read channel (AR + R) bundle between a read master and a read
//   slave.
//   master modport : drives arvalid/araddr/arprot/rready, samples arready/rvalid/rdata/rresp
//   slave modport  : the mirror image, for slave read ports and bench models
interface maxil_read_top_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/maxil_read_top.sv
// maxil_read_top
//   AXI4-Lite read master. Turns a single local command (address, prot) into
//   one AXI4-Lite read and returns data, response code and the measured
//   latency on a local response port. One transaction in flight at a time.
//   Ports:
//     maxil_read_top_clk / maxil_read_top_rst : clock, synchronous active-high reset
//     cmd_valid/cmd_ready/cmd_addr/cmd_prot   : local command handshake
//     maxil_read (master modport)             : AXI4-Lite AR and R channels
//     rsp_valid/rsp_ready/rsp_data/rsp_resp/rsp_latency : local response handshake
//     err_count                               : saturating count of non-OKAY responses
//     busy                                    : high whenever not IDLE
//
//   state | meaning
//   IDLE  | waiting for a local command, cmd_ready high
//   ADDR  | arvalid high, waiting for arready
//   DATA  | rready high, waiting for rvalid
//   RESP  | rsp_valid high, waiting for rsp_ready
module maxil_read_top #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 8,
  parameter int ERR_W  = 8
) (
  input  logic              maxil_read_top_clk,
  input  logic              maxil_read_top_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_prot,
  maxil_read_top_if.master  maxil_read,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic [LAT_W-1:0]  rsp_latency,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e            state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [LAT_W-1:0]  rsp_latency_q, rsp_latency_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]  lat_inc;

  // Masked by reset so no command can be taken while reset is asserted.
  assign cmd_ready = (state_q == IDLE) && !maxil_read_top_rst;
  assign busy      = (state_q != IDLE);

  assign maxil_read.arvalid = arvalid_q;
  assign maxil_read.araddr  = araddr_q;
  assign maxil_read.arprot  = arprot_q;
  assign maxil_read.rready  = rready_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_latency = rsp_latency_q;
  assign err_count   = err_count_q;

  // Latency counter sticks at all-ones instead of wrapping.
  assign lat_inc = (lat_cnt_q == {LAT_W{1'b1}}) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

  always_comb begin
    state_d       = state_q;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    arprot_d      = arprot_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_latency_d = rsp_latency_q;
    err_count_d   = err_count_q;
    lat_cnt_d     = lat_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          araddr_d  = cmd_addr;
          arprot_d  = cmd_prot;
          arvalid_d = 1'b1;
          lat_cnt_d = LAT_W'(1);
          state_d   = ADDR;
        end
      end
      ADDR: begin
        lat_cnt_d = lat_inc;
        if (arvalid_q && maxil_read.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (maxil_read.rvalid && rready_q) begin
          rsp_data_d    = maxil_read.rdata;
          rsp_resp_d    = maxil_read.rresp;
          rsp_latency_d = lat_cnt_q;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          if ((maxil_read.rresp != 2'b00) && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_inc;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge maxil_read_top_clk) begin
    if (maxil_read_top_rst) begin
      state_q       <= IDLE;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arprot_q      <= '0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= '0;
      rsp_latency_q <= '0;
      err_count_q   <= '0;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      arprot_q      <= arprot_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_latency_q <= rsp_latency_d;
      err_count_q   <= err_count_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_maxil_read_top.sv
// tb_maxil_read_top
//   Directed bench for maxil_read_top. The main instance uses default widths;
//   a second instance with LAT_W=3 covers latency saturation. Inputs are
//   driven and outputs sampled just after the falling clock edge.
module tb_maxil_read_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [7:0]  rsp_latency, err_count;
  logic        busy;

  maxil_read_top_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  maxil_read_top u_dut (
    .maxil_read_top_clk (clk),
    .maxil_read_top_rst (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_prot           (cmd_prot),
    .maxil_read         (axi),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_resp           (rsp_resp),
    .rsp_latency        (rsp_latency),
    .err_count          (err_count),
    .busy               (busy)
  );

  // second instance, 3-bit latency counter
  logic        cmd_valid3, cmd_ready3;
  logic [31:0] cmd_addr3;
  logic [2:0]  cmd_prot3;
  logic        rsp_valid3, rsp_ready3;
  logic [31:0] rsp_data3;
  logic [1:0]  rsp_resp3;
  logic [2:0]  rsp_latency3;
  logic [7:0]  err_count3;
  logic        busy3;

  maxil_read_top_if #(.ADDR_W(32), .DATA_W(32)) axi3 ();

  maxil_read_top #(.LAT_W(3)) u_dut3 (
    .maxil_read_top_clk (clk),
    .maxil_read_top_rst (rst),
    .cmd_valid          (cmd_valid3),
    .cmd_ready          (cmd_ready3),
    .cmd_addr           (cmd_addr3),
    .cmd_prot           (cmd_prot3),
    .maxil_read         (axi3),
    .rsp_valid          (rsp_valid3),
    .rsp_ready          (rsp_ready3),
    .rsp_data           (rsp_data3),
    .rsp_resp           (rsp_resp3),
    .rsp_latency        (rsp_latency3),
    .err_count          (err_count3),
    .busy               (busy3)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full read on the main instance. Called just after a falling edge with
  // the DUT in IDLE; returns just after a falling edge with the DUT in IDLE.
  task automatic run_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                          input int ar_stall, input int r_stall,
                          input logic [31:0] data, input logic [1:0] resp,
                          input int rsp_stall, input int exp_lat);
    int n;
    chk({tag, ":cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_prot  = prot;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_prot  = '0;
    n = 0;
    while (axi.arvalid && n < 64) begin
      chk({tag, ":araddr"}, axi.araddr, addr);
      chk({tag, ":arprot"}, axi.arprot, prot);
      axi.arready = (n >= ar_stall);
      n++;
      @(negedge clk); #1;
    end
    axi.arready = 1'b0;
    chk({tag, ":ar_cycles"}, n, ar_stall + 1);
    n = 0;
    while (axi.rready && n < 64) begin
      axi.rvalid = (n >= r_stall);
      axi.rdata  = data;
      axi.rresp  = resp;
      n++;
      @(negedge clk); #1;
    end
    axi.rvalid = 1'b0;
    axi.rdata  = '0;
    axi.rresp  = '0;
    chk({tag, ":r_cycles"}, n, r_stall + 1);
    for (int i = 0; i < rsp_stall; i++) begin
      chk({tag, ":hold_valid"}, rsp_valid, 1);
      chk({tag, ":hold_data"}, rsp_data, data);
      chk({tag, ":hold_cmd_ready"}, cmd_ready, 0);
      chk({tag, ":hold_busy"}, busy, 1);
      cmd_valid = 1'b1;
      cmd_addr  = ~addr;
      @(negedge clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    chk({tag, ":rsp_valid"}, rsp_valid, 1);
    chk({tag, ":rsp_data"}, rsp_data, data);
    chk({tag, ":rsp_resp"}, rsp_resp, resp);
    chk({tag, ":rsp_latency"}, rsp_latency, exp_lat);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ":rsp_done"}, rsp_valid, 0);
    chk({tag, ":no_stray_ar"}, axi.arvalid, 0);
    chk({tag, ":idle_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    cmd_valid = 0; cmd_addr = '0; cmd_prot = '0; rsp_ready = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    cmd_valid3 = 0; cmd_addr3 = '0; cmd_prot3 = '0; rsp_ready3 = 0;
    axi3.arready = 0; axi3.rvalid = 0; axi3.rdata = '0; axi3.rresp = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst:cmd_ready", cmd_ready, 0);
    chk("rst:arvalid", axi.arvalid, 0);
    chk("rst:araddr", axi.araddr, 0);
    chk("rst:arprot", axi.arprot, 0);
    chk("rst:rready", axi.rready, 0);
    chk("rst:rsp_valid", rsp_valid, 0);
    chk("rst:rsp_data", rsp_data, 0);
    chk("rst:rsp_resp", rsp_resp, 0);
    chk("rst:rsp_latency", rsp_latency, 0);
    chk("rst:err_count", err_count, 0);
    chk("rst:busy", busy, 0);
    rst = 1'b0;
    #1;

    // zero-wait read
    run_read("zero_wait", 32'hFFFF_FFFF, 3'd0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 2);
    chk("zero_wait:err_count", err_count, 0);

    // AR stall of 3 cycles
    run_read("ar_stall", 32'hF0F0_F0F0, 3'b101, 3, 0, 32'h1234_5678, 2'b00, 0, 5);
    chk("ar_stall:err_count", err_count, 0);

    // R stall of 5 cycles with SLVERR
    run_read("r_stall_err", 32'h0000_1000, 3'd0, 0, 5, 32'hCAFE_F00D, 2'b10, 0, 7);
    chk("r_stall_err:err_count", err_count, 1);

    // response backpressure, mixed stalls, EXOKAY counts as non-OKAY
    run_read("backpressure", 32'h0000_2000, 3'b010, 1, 2, 32'hA5A5_A5A5, 2'b01, 4, 5);
    chk("backpressure:err_count", err_count, 2);

    // latency saturation on the LAT_W=3 instance: 1 + 1 + 20 = 22 -> 7
    cmd_valid3 = 1'b1;
    cmd_addr3  = 32'h0000_0040;
    @(negedge clk); #1;
    cmd_valid3 = 1'b0;
    chk("lat_sat:arvalid", axi3.arvalid, 1);
    axi3.arready = 1'b1;
    @(negedge clk); #1;
    axi3.arready = 1'b0;
    n = 0;
    while (axi3.rready && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    chk("lat_sat:rready_cycles", n, 20);
    axi3.rvalid = 1'b1;
    axi3.rdata  = 32'h0BAD_F00D;
    @(negedge clk); #1;
    axi3.rvalid = 1'b0;
    chk("lat_sat:rsp_valid", rsp_valid3, 1);
    chk("lat_sat:rsp_latency", rsp_latency3, 7);
    chk("lat_sat:rsp_data", rsp_data3, 32'h0BAD_F00D);
    rsp_ready3 = 1'b1;
    @(negedge clk); #1;
    rsp_ready3 = 1'b0;
    chk("lat_sat:rsp_done", rsp_valid3, 0);

    // error counter saturation: 2 + 260 errors -> 255
    for (int i = 0; i < 260; i++) begin
      run_read("err_sat", 32'(i) << 2, 3'd0, 0, 0, 32'(i), 2'b10, 0, 2);
    end
    chk("err_sat:err_count", err_count, 255);

    // reset while in DATA
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0080;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    axi.arready = 1'b1;
    @(negedge clk); #1;
    axi.arready = 1'b0;
    chk("mid_rst:in_data", axi.rready, 1);
    chk("mid_rst:busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst:rready", axi.rready, 0);
    chk("mid_rst:busy", busy, 0);
    chk("mid_rst:err_count", err_count, 0);
    chk("mid_rst:cmd_ready", cmd_ready, 0);
    chk("mid_rst:arvalid", axi.arvalid, 0);
    chk("mid_rst:rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    #1;
    run_read("after_rst", 32'h0000_0010, 3'd0, 0, 0, 32'h1122_3344, 2'b00, 0, 2);
    chk("after_rst:err_count", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/maxil_read_top.md
# maxil_read_top

AXI4-Lite read master: the initiator side of the AXI4-Lite read channel, driving AR and accepting R from a slave read port. It converts a single-beat local command (address, protection) into one AXI4-Lite read transaction and returns data, response code and measured latency on a local response port. One transaction outstanding at a time. It sits between local control logic and the AXI-Lite interconnect, and pairs directly with our slave read port in loopback benches.

## Interface
- ADDR_W, 32, address width of cmd_addr / araddr
- DATA_W, 32, data width of rdata / rsp_data
- LAT_W, 8, width of latency counter and rsp_latency (saturating)
- ERR_W, 8, width of err_count (saturating)

- maxil_read_top_clk  in  1  single clock, all logic rising-edge
- maxil_read_top_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  local command valid
- cmd_ready  out  1  local command ready
- cmd_addr  in  ADDR_W  read address
- cmd_prot  in  3  AXI protection bits
- maxil_read_arvalid  out  1  AR valid
- maxil_read_arready  in  1  AR ready
- maxil_read_araddr  out  ADDR_W  AR address
- maxil_read_arprot  out  3  AR protection
- maxil_read_rvalid  in  1  R valid
- maxil_read_rready  out  1  R ready
- maxil_read_rdata  in  DATA_W  R data
- maxil_read_rresp  in  2  R response
- rsp_valid  out  1  local response valid
- rsp_ready  in  1  local response ready
- rsp_data  out  DATA_W  captured rdata
- rsp_resp  out  2  captured rresp
- rsp_latency  out  LAT_W  cycles from first arvalid cycle to R handshake cycle, inclusive
- err_count  out  ERR_W  count of responses with rresp != 2'b00
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Reset -> IDLE.
- IDLE: cmd_ready = 1 (combinational: state==IDLE && !rst). On cmd_valid && cmd_ready: araddr <= cmd_addr, arprot <= cmd_prot, arvalid <= 1, lat_cnt <= 1, -> ADDR.
- ADDR: arvalid held 1, araddr/arprot stable until handshake. On arvalid && arready: arvalid <= 0, rready <= 1, -> DATA. Otherwise stay.
- DATA: rready held 1. On rvalid && rready: rsp_data <= rdata, rsp_resp <= rresp, rsp_latency <= lat_cnt, rready <= 0, rsp_valid <= 1, -> RESP. If rresp != 0, err_count increments (saturates at all-ones).
- RESP: rsp_valid held 1, rsp_data/resp/latency stable. On rsp_valid && rsp_ready: rsp_valid <= 0, -> IDLE. No new command is accepted in the same cycle.
- lat_cnt: in ADDR and DATA, increments by 1 every cycle without an R handshake; saturates at 2^LAT_W-1, never wraps.
- rvalid outside DATA is ignored (rready is 0). arready outside ADDR is ignored.
- err_count cleared only by reset; persists across transactions.

## Timing
- Reset values: arvalid 0, araddr 0, arprot 0, rready 0, rsp_valid 0, rsp_data 0, rsp_resp 0, rsp_latency 0, err_count 0, busy 0, cmd_ready 0 while rst is high.
- All AXI and rsp outputs are registered; only cmd_ready is combinational.
- Best case: command accepted at edge N; arvalid high in cycle N+1; AR handshake at edge N+1; rready high in cycle N+2; R handshake at edge N+2; rsp_valid high in cycle N+3; rsp_latency = 2.
- Each additional arready or rvalid stall cycle adds 1 to rsp_latency.
- Minimum command-to-command spacing: 4 cycles (IDLE, ADDR, DATA, RESP), given rsp_ready held high.
- Reset asserted mid-transaction: at the next edge all outputs take reset values and state -> IDLE; the in-flight transaction is abandoned. The interconnect must be reset in the same cycle.

## Test plan
- Single read, zero wait: cmd_addr=32'hFFFF_FFFF, prot=0, arready=1, rvalid=1 with rdata=32'hDEAD_BEEF, rresp=0, rsp_ready=1 -> araddr=FFFF_FFFF for 1 cycle; rsp_data=DEAD_BEEF, rsp_resp=0, rsp_latency=2, err_count=0.
- AR stall: arready low for 3 cycles, then high; rvalid immediate; cmd_addr=32'hF0F0_F0F0 -> arvalid and araddr stable for 4 cycles, rsp_latency=5.
- R stall plus error: rvalid delayed 5 cycles, rresp=2'b10 -> rready high for 6 cycles, rsp_resp=2'b10, rsp_latency=7, err_count=1.
- Response backpressure: rsp_ready low for 4 cycles after rsp_valid -> rsp_valid/data held, cmd_ready=0, busy=1; new command accepted only after rsp_ready handshake.
- Saturation, LAT_W=3: rvalid delayed 20 cycles -> rsp_latency=7. Also 260 back-to-back SLVERR reads with ERR_W=8 -> err_count=255.
- Reset mid-transaction: assert rst while in DATA -> next edge rready=0, busy=0, err_count=0; a following read of 32'h0000_0010 completes normally with latency 2.
